// File: rtl/mux4_arb_pkg.sv
// Shared types and the rotating-priority search for the 4-source arbiter.
package mux4_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scans farthest-first so the candidate nearest to ptr is the one kept.
    function automatic pick_t rr_pick(
        input logic [N_REQ-1:0] req,
        input logic [SEL_W-1:0] ptr
    );
        pick_t            p;
        logic [SEL_W-1:0] c;
        p = '0;
        for (int d = N_REQ - 1; d >= 0; d--) begin
            c = ptr + SEL_W'(d);
            if (req[c]) begin
                p.found = 1'b1;
                p.idx   = c;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/data bundle between the four sources and the arbiter.
interface mux4_rr_arbiter_if;
    import mux4_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data_in;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [SEL_W-1:0] sel;
    logic             data_out;

    modport master (
        output req,
        output data_in,
        input  gnt,
        input  gnt_valid,
        input  sel,
        input  data_out
    );

    modport slave (
        input  req,
        input  data_in,
        output gnt,
        output gnt_valid,
        output sel,
        output data_out
    );

endinterface

// File: rtl/mux4_rr_arbiter_mux_4x1.sv
// Plain single-bit 4:1 multiplexer used for the shared data path.
module mux_4x1 (
    input  logic [3:0] in,
    input  logic [1:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of one shared serial line among four sources.
// Define ARB_HOLD_LIMIT_EN to pre-empt an owner after MAX_HOLD cycles.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux4_rr_arbiter_if.slave arb
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("mux4_rr_arbiter: illegal MAX_HOLD/CNT_W");
    end

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             vld_q, vld_d;
    logic [N_REQ-1:0] others;
    logic             rel;
    logic             preempt;
    logic             mux_out;
    pick_t            pk_idle;
    pick_t            pk_next;

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_q, hold_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`endif

    // While granted, sel_q is the owner index.
    assign others  = arb.req & ~(N_REQ'(1) << sel_q);
    assign rel     = ~arb.req[sel_q];
    assign pk_idle = rr_pick(arb.req, ptr_q);
    assign pk_next = rr_pick(others, sel_q + SEL_W'(1));

`ifdef ARB_HOLD_LIMIT_EN
    assign preempt = arb.req[sel_q] && pk_next.found
                  && (hold_q == CNT_W'(MAX_HOLD - 1));
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        vld_d   = vld_q;
`ifdef ARB_HOLD_LIMIT_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pk_idle.found) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << pk_idle.idx;
                    sel_d   = pk_idle.idx;
                    vld_d   = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (rel || preempt) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (pk_next.found) begin
                        gnt_d  = N_REQ'(1) << pk_next.idx;
                        sel_d  = pk_next.idx;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else begin
`ifdef ARB_HOLD_LIMIT_EN
                    if (hold_q != '1) hold_d = hold_q + CNT_W'(1);
`endif
                end
            end
        endcase
    end

    mux_4x1 u_mux (
        .in  (arb.data_in),
        .sel (sel_q),
        .out (mux_out)
    );

    assign arb.gnt       = gnt_q;
    assign arb.gnt_valid = vld_q;
    assign arb.sel       = sel_q;
    assign arb.data_out  = mux_out & vld_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized bench for mux4_rr_arbiter against a behavioural owner/pointer model.
module tb_mux4_rr_arbiter;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int MAXH = 4;
`else
    localparam int MAXH = 8;
`endif

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    int   m_own;
    int   m_ptr;
    int   m_sel;
    int   m_hold;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_HOLD (MAXH),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int d = 0; d < 4; d++) begin
            if (r[(start + d) % 4]) return (start + d) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic rs);
        logic [3:0] oth;
        bit         pre;
        int         nx;
        if (rs) begin
            m_own = -1; m_ptr = 0; m_sel = 0; m_hold = 0;
        end else if (m_own < 0) begin
            nx = first_from(r, m_ptr);
            if (nx >= 0) begin
                m_own = nx; m_sel = nx; m_hold = 0;
            end
        end else begin
            oth = r;
            oth[m_own] = 1'b0;
            pre = 0;
`ifdef ARB_HOLD_LIMIT_EN
            pre = r[m_own] && (oth != 0) && (m_hold == MAXH - 1);
`endif
            if (!r[m_own] || pre) begin
                m_ptr = (m_own + 1) % 4;
                nx = first_from(oth, m_ptr);
                if (nx >= 0) begin
                    m_own = nx; m_sel = nx; m_hold = 0;
                end else begin
                    m_own = -1;
                end
            end else if (m_hold < 255) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    function automatic logic [3:0] e_gnt();
        logic [3:0] g;
        g = 4'b0000;
        if (m_own >= 0) g[m_own] = 1'b1;
        return g;
    endfunction

    function automatic logic e_dout();
        return (m_own >= 0) ? bus.data_in[m_sel] : 1'b0;
    endfunction

    task automatic tick();
        model_edge(bus.req, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.data_in = 4'b1111;
        tick();
        tick();
        nvec++;
        if (bus.gnt !== 4'b0000) begin
            nerr++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt);
        end
        nvec++;
        if (bus.gnt_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_valid got=%b want=0", bus.gnt_valid);
        end
        nvec++;
        if (bus.sel !== 2'd0) begin
            nerr++; $display("FAIL reset_sel got=%0d want=0", bus.sel);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.data_in = 4'($urandom);
            tick();
            nvec++;
            if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0
                || bus.sel !== 2'd0 || bus.data_out !== 1'b0) begin
                nerr++;
                $display("FAIL idle_quiet got=%b/%b/%0d/%b want=0000/0/0/0",
                         bus.gnt, bus.gnt_valid, bus.sel, bus.data_out);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        tick();
        nvec++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2 || bus.gnt_valid !== 1'b1) begin
            nerr++;
            $display("FAIL single_grant got=%b/%0d/%b want=0100/2/1",
                     bus.gnt, bus.sel, bus.gnt_valid);
        end
        for (int i = 0; i < 6; i++) begin
            bus.data_in = 4'($urandom);
            #1;
            nvec++;
            if (bus.data_out !== bus.data_in[2]) begin
                nerr++;
                $display("FAIL single_data got=%b want=%b", bus.data_out, bus.data_in[2]);
            end
            tick();
        end
    endtask

    task automatic test_rotation();
        logic [3:0] want;
        do_reset();
        bus.req = 4'b1111;
        tick();
        nvec++;
        if (bus.gnt !== 4'b0001) begin
            nerr++; $display("FAIL rot_first got=%b want=0001", bus.gnt);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            bus.req = 4'b1111 & ~(4'b0001 << k);
            tick();
            bus.req = 4'b1111;
            want = 4'b0001 << ((k + 1) % 4);
            nvec++;
            if (bus.gnt !== want || bus.gnt_valid !== 1'b1) begin
                nerr++;
                $display("FAIL rot_handoff%0d got=%b/%b want=%b/1",
                         k, bus.gnt, bus.gnt_valid, want);
            end
        end
    endtask

    task automatic test_ptr_handoff();
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b1001;
        tick();
        nvec++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
            nerr++;
            $display("FAIL ptr_handoff got=%b/%0d want=1000/3", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req = 4'b0100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if (bus.gnt !== 4'b0000 || bus.sel !== 2'd0 || bus.gnt_valid !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid got=%b/%0d/%b want=0000/0/0",
                     bus.gnt, bus.sel, bus.gnt_valid);
        end
        bus.req = 4'b0110;
        tick();
        nvec++;
        if (bus.gnt !== 4'b0010 || bus.sel !== 2'd1) begin
            nerr++;
            $display("FAIL reset_regrant got=%b/%0d want=0010/1", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_hold();
        logic [3:0] want;
        do_reset();
        bus.req = 4'b0011;
        for (int t = 1; t <= 16; t++) begin
            tick();
`ifdef ARB_HOLD_LIMIT_EN
            want = 4'b0001 << (((t - 1) / MAXH) % 2);
`else
            want = 4'b0001;
`endif
            nvec++;
            if (bus.gnt !== want) begin
                nerr++; $display("FAIL hold_pair t=%0d got=%b want=%b", t, bus.gnt, want);
            end
        end
        do_reset();
        bus.req = 4'b0001;
        for (int t = 1; t <= 20; t++) begin
            tick();
            nvec++;
            if (bus.gnt !== 4'b0001 || bus.gnt_valid !== 1'b1) begin
                nerr++;
                $display("FAIL hold_alone t=%0d got=%b/%b want=0001/1",
                         t, bus.gnt, bus.gnt_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3, 0) == 0) r[b] = ~r[b];
            end
            bus.req = r;
            bus.data_in = 4'($urandom);
            rst = ($urandom_range(63, 0) == 0);
            tick();
            nvec++;
            if (bus.gnt !== e_gnt() || bus.gnt_valid !== (m_own >= 0)
                || bus.sel !== 2'(m_sel) || bus.data_out !== e_dout()) begin
                nerr++;
                $display("FAIL rand%0d got=%b/%b/%0d/%b want=%b/%b/%0d/%b",
                         i, bus.gnt, bus.gnt_valid, bus.sel, bus.data_out,
                         e_gnt(), (m_own >= 0), m_sel, e_dout());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        m_own = -1; m_ptr = 0; m_sel = 0; m_hold = 0;
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.data_in = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_ptr_handoff();
        test_reset_mid();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
